// File: rtl/ifid_pipe.sv
// IF/ID pipeline stage: skid FIFO absorbing fetch words during hazard stalls,
// feeding a registered instruction-field decoder with flush and bypass paths.
module ifid_pipe #(
   parameter int          PC_W        = 32,
   parameter int          DEPTH       = 2,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
   parameter int          ZERO_UNUSED = 0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [PC_W-1:0]            PC4,
   input  logic [31:0]                instrucao,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       IFIDWrite,
   input  logic                       flush,
   output logic                       out_valid,
   output logic [PC_W-1:0]            PC4_out,
   output logic [5:0]                 opcode,
   output logic [4:0]                 rs,
   output logic [4:0]                 rt,
   output logic [4:0]                 rd,
   output logic [4:0]                 shamt,
   output logic [5:0]                 funct,
   output logic [15:0]                address,
   output logic [25:0]                addressJump,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   // Field pack order: opcode, rs, rt, rd, shamt, funct, address, addressJump.
   function automatic logic [73:0] decode(input logic [31:0] w);
      logic [5:0]  f_op;
      logic [4:0]  f_rs, f_rt, f_rd, f_sh;
      logic [5:0]  f_fn;
      logic [15:0] f_ad;
      logic [25:0] f_aj;
      f_op = w[31:26];
      f_rs = w[25:21];
      f_rt = w[20:16];
      f_rd = w[15:11];
      f_sh = w[10:6];
      f_fn = w[5:0];
      f_ad = w[15:0];
      f_aj = w[25:0];
      if (ZERO_UNUSED != 0) begin
         case (f_op)
            6'b000000: begin
               f_ad = '0;
               f_aj = '0;
            end
            6'b100011, 6'b101011, 6'b001001, 6'b001010, 6'b000100: begin
               f_rd = '0;
               f_sh = '0;
               f_fn = '0;
               f_aj = '0;
            end
            default: begin
               f_rs = '0;
               f_rt = '0;
               f_rd = '0;
               f_sh = '0;
               f_fn = '0;
               f_ad = '0;
            end
         endcase
      end
      return {f_op, f_rs, f_rt, f_rd, f_sh, f_fn, f_ad, f_aj};
   endfunction

   localparam logic [73:0] NOP_FIELDS = decode(NOP_INSTR);

   logic [PC_W-1:0] mem_pc [DEPTH];
   logic [31:0]     mem_in [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [73:0]     fields_q;

   logic            xfer, load, pop, bypass, push;
   logic            sel_valid;
   logic [PC_W-1:0] sel_pc;
   logic [31:0]     sel_instr;

   assign in_ready = reset_n && !flush && (count < CW'(DEPTH));
   assign xfer     = in_valid && in_ready;
   assign load     = IFIDWrite && !flush;
   assign pop      = load && (count != '0);
   assign bypass   = load && (count == '0) && xfer;
   assign push     = xfer && !bypass;

   assign {opcode, rs, rt, rd, shamt, funct, address, addressJump} = fields_q;

   always_comb begin
      sel_valid = 1'b0;
      sel_pc    = '0;
      sel_instr = NOP_INSTR;
      if (pop) begin
         sel_valid = 1'b1;
         sel_pc    = mem_pc[rd_ptr];
         sel_instr = mem_in[rd_ptr];
      end else if (bypass) begin
         sel_valid = 1'b1;
         sel_pc    = PC4;
         sel_instr = instrucao;
      end
   end

   // Storage needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_pc[wr_ptr] <= PC4;
         mem_in[wr_ptr] <= instrucao;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         PC4_out   <= '0;
         fields_q  <= NOP_FIELDS;
      end else if (flush) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         PC4_out   <= '0;
         fields_q  <= NOP_FIELDS;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (load) begin
            out_valid <= sel_valid;
            PC4_out   <= sel_pc;
            fields_q  <= decode(sel_instr);
         end
      end
   end

endmodule

// File: tb/tb_ifid_pipe.sv
// Directed bench for ifid_pipe: scoreboard of hand-decoded words checked by a
// monitor on each load, plus direct checks of occupancy, ready and squash states.
module tb_ifid_pipe;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] ad;
      logic [25:0] aj;
   } exp_t;

   logic        clock, reset_n;
   logic [31:0] PC4, instrucao;
   logic        in_valid, IFIDWrite, flush;

   logic        in_ready, out_valid;
   logic [31:0] PC4_out;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] address;
   logic [25:0] addressJump;
   logic [1:0]  count;

   logic        in_ready_z, out_valid_z;
   logic [31:0] PC4_out_z;
   logic [5:0]  opcode_z, funct_z;
   logic [4:0]  rs_z, rt_z, rd_z, shamt_z;
   logic [15:0] address_z;
   logic [25:0] addressJump_z;
   logic [1:0]  count_z;

   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t sb[$];
   exp_t e;
   logic was_load = 1'b0;

   ifid_pipe u_dut (
      .clock(clock), .reset_n(reset_n), .PC4(PC4), .instrucao(instrucao),
      .in_valid(in_valid), .in_ready(in_ready), .IFIDWrite(IFIDWrite), .flush(flush),
      .out_valid(out_valid), .PC4_out(PC4_out), .opcode(opcode), .rs(rs), .rt(rt),
      .rd(rd), .shamt(shamt), .funct(funct), .address(address),
      .addressJump(addressJump), .count(count)
   );

   ifid_pipe #(.ZERO_UNUSED(1)) u_dz (
      .clock(clock), .reset_n(reset_n), .PC4(PC4), .instrucao(instrucao),
      .in_valid(in_valid), .in_ready(in_ready_z), .IFIDWrite(IFIDWrite), .flush(flush),
      .out_valid(out_valid_z), .PC4_out(PC4_out_z), .opcode(opcode_z), .rs(rs_z),
      .rt(rt_z), .rd(rd_z), .shamt(shamt_z), .funct(funct_z), .address(address_z),
      .addressJump(addressJump_z), .count(count_z)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins,
                               input logic [5:0] op, input logic [4:0] f_rs,
                               input logic [4:0] f_rt, input logic [4:0] f_rd,
                               input logic [4:0] f_sh, input logic [5:0] f_fn,
                               input logic [15:0] f_ad, input logic [25:0] f_aj);
      exp_t v;
      v.pc = pc; v.ins = ins; v.op = op; v.rs = f_rs; v.rt = f_rt; v.rd = f_rd;
      v.sh = f_sh; v.fn = f_fn; v.ad = f_ad; v.aj = f_aj;
      return v;
   endfunction

   task automatic offer(input exp_t v);
      PC4       = v.pc;
      instrucao = v.ins;
      in_valid  = 1'b1;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Monitor: every load that yields a valid word consumes the oldest expectation.
   always @(posedge clock) was_load <= reset_n && IFIDWrite && !flush;

   always @(negedge clock) begin
      if (was_load && out_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL mon_unexpected: got pc %h ins-op %h, expected no output", PC4_out, opcode);
         end else begin
            e = sb.pop_front();
            chk("mon_pc", PC4_out, e.pc);
            chk("mon_opcode", {26'd0, opcode}, {26'd0, e.op});
            chk("mon_rs", {27'd0, rs}, {27'd0, e.rs});
            chk("mon_rt", {27'd0, rt}, {27'd0, e.rt});
            chk("mon_rd", {27'd0, rd}, {27'd0, e.rd});
            chk("mon_shamt", {27'd0, shamt}, {27'd0, e.sh});
            chk("mon_funct", {26'd0, funct}, {26'd0, e.fn});
            chk("mon_address", {16'd0, address}, {16'd0, e.ad});
            chk("mon_addrjump", {6'd0, addressJump}, {6'd0, e.aj});
         end
      end
   end

   initial begin
      exp_t v0, va, vb, vc, vd, ve, vf, vg, vh, vj;
      v0 = mk(32'h104, 32'h8C22_0004, 6'h23, 5'd1,  5'd2,  5'd0,  5'd0,  6'h04, 16'h0004, 26'h022_0004);
      va = mk(32'h108, 32'h0022_1820, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h1820, 26'h022_1820);
      vb = mk(32'h10C, 32'h3C01_1234, 6'h0F, 5'd0,  5'd1,  5'd2,  5'd8,  6'h34, 16'h1234, 26'h001_1234);
      vc = mk(32'h110, 32'hAFBF_0010, 6'h2B, 5'd29, 5'd31, 5'd0,  5'd0,  6'h10, 16'h0010, 26'h3BF_0010);
      vd = mk(32'h114, 32'h1234_5678, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h000_0000);
      ve = mk(32'h118, 32'h2345_6789, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h000_0000);
      vf = mk(32'h11C, 32'h3456_789A, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h000_0000);
      vg = mk(32'h120, 32'h2128_FFFF, 6'h08, 5'd9,  5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h128_FFFF);
      vh = mk(32'h124, 32'h4567_89AB, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h000_0000);
      vj = mk(32'h128, 32'h0800_0040, 6'h02, 5'd0,  5'd0,  5'd0,  5'd1,  6'h00, 16'h0040, 26'h000_0040);

      reset_n = 1'b0; PC4 = '0; instrucao = '0; in_valid = 1'b0; IFIDWrite = 1'b0; flush = 1'b0;
      #3;
      chk("rst_count", {30'd0, count}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_pc4_out", PC4_out, 32'd0);
      chk("rst_opcode", {26'd0, opcode}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Bypass with empty FIFO
      IFIDWrite = 1'b1; offer(v0); sb.push_back(v0);
      tick();
      chk("byp_count", {30'd0, count}, 32'd0);
      chk("byp_z_address", {16'd0, address_z}, 32'h0004);
      chk("byp_z_funct", {26'd0, funct_z}, 32'd0);
      chk("byp_z_addrjump", {6'd0, addressJump_z}, 32'd0);
      chk("byp_z_rs", {27'd0, rs_z}, 32'd1);

      // Load with nothing available -> bubble
      in_valid = 1'b0;
      tick();
      chk("bub_out_valid", {31'd0, out_valid}, 32'd0);
      chk("bub_pc4_out", PC4_out, 32'd0);
      chk("bub_opcode", {26'd0, opcode}, 32'd0);
      chk("bub_funct", {26'd0, funct}, 32'd0);

      // Stall fill
      IFIDWrite = 1'b0; offer(va); sb.push_back(va);
      tick();
      chk("fill1_count", {30'd0, count}, 32'd1);
      chk("fill1_in_ready", {31'd0, in_ready}, 32'd1);
      offer(vb); sb.push_back(vb);
      tick();
      chk("fill2_count", {30'd0, count}, 32'd2);
      chk("fill2_in_ready", {31'd0, in_ready}, 32'd0);
      chk("fill2_out_held", {31'd0, out_valid}, 32'd0);

      // Full: offered word waits, then is accepted while draining
      IFIDWrite = 1'b1; offer(vc); sb.push_back(vc);
      #1 chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("pop1_count", {30'd0, count}, 32'd1);
      chk("pop1_z_rd", {27'd0, rd_z}, 32'd3);
      chk("pop1_z_address", {16'd0, address_z}, 32'd0);
      chk("pop1_z_addrjump", {6'd0, addressJump_z}, 32'd0);
      tick();
      chk("pushpop_count", {30'd0, count}, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("drain_count", {30'd0, count}, 32'd0);

      // Flush while stalled and full, with a same-cycle offer
      IFIDWrite = 1'b0; offer(vd);
      tick();
      offer(ve);
      tick();
      chk("pre_flush_count", {30'd0, count}, 32'd2);
      chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_flush_pc", PC4_out, 32'h110);
      flush = 1'b1; offer(vf);
      #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", {30'd0, count}, 32'd0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_pc4_out", PC4_out, 32'd0);
      chk("flush_opcode", {26'd0, opcode}, 32'd0);
      IFIDWrite = 1'b1;
      tick();
      chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
      chk("post_flush_count", {30'd0, count}, 32'd0);

      // Asynchronous reset between edges with one entry queued
      offer(vg); sb.push_back(vg);
      tick();
      IFIDWrite = 1'b0; offer(vh);
      tick();
      chk("pre_rst_count", {30'd0, count}, 32'd1);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_count", {30'd0, count}, 32'd0);
      chk("arst_pc4_out", PC4_out, 32'd0);
      #1 reset_n = 1'b1;
      IFIDWrite = 1'b1;
      tick();
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_count", {30'd0, count}, 32'd0);

      // Jump-format word, checked against both field policies
      offer(vj); sb.push_back(vj);
      tick();
      in_valid = 1'b0;
      chk("jmp_z_opcode", {26'd0, opcode_z}, 32'h02);
      chk("jmp_z_addrjump", {6'd0, addressJump_z}, 32'h40);
      chk("jmp_z_shamt", {27'd0, shamt_z}, 32'd0);
      chk("jmp_z_address", {16'd0, address_z}, 32'd0);
      chk("jmp_z_rs", {27'd0, rs_z}, 32'd0);
      tick();
      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ifid_pipe.md
IFID_PIPE -- requirements
Module: ifid_pipe

Interface
REQ-001 Parameter PC_W, default 32, width of PC4 and PC4_out.
REQ-002 Parameter DEPTH, default 2, skid-FIFO entries; power of two, at least 2.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0000, instruction decoded into the fields when the stage is empty or flushed.
REQ-004 Parameter ZERO_UNUSED, default 0; when 1, fields not belonging to the decoded format SHALL be driven 0.
REQ-005 clock  in  1  rising-edge clock; the only clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 PC4  in  PC_W  PC+4 of the fetched instruction.
REQ-008 instrucao  in  32  fetched instruction.
REQ-009 in_valid  in  1  fetch offers {PC4, instrucao} this cycle.
REQ-010 in_ready  out  1  stage accepts the offer this cycle.
REQ-011 IFIDWrite  in  1  hazard-unit enable; 0 = hold the output register.
REQ-012 flush  in  1  synchronous squash (branch/jump taken).
REQ-013 out_valid  out  1  output fields hold a real instruction.
REQ-014 PC4_out  out  PC_W; opcode  out  6; rs, rt, rd, shamt  out  5 each; funct  out  6; address  out  16; addressJump  out  26 -- registered decode outputs.
REQ-015 count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-016 A transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge; in_ready SHALL be (count<DEPTH) and flush=0, combinational.
REQ-017 The output register SHALL load when IFIDWrite=1 and SHALL hold all outputs, including out_valid, when IFIDWrite=0.
REQ-018 On a load with count>0, the FIFO head SHALL go to the output (pop); a same-cycle transfer SHALL be pushed, leaving count unchanged.
REQ-019 On a load with count=0 and a transfer, the input SHALL bypass to the output in 1 cycle, and count SHALL stay 0.
REQ-020 On a load with count=0 and no transfer, out_valid SHALL become 0, PC4_out SHALL become 0, and the fields SHALL decode NOP_INSTR.
REQ-021 A transfer while IFIDWrite=0 SHALL push into the FIFO; entries SHALL leave in arrival order.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-023 Decode bit positions: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], address [15:0], addressJump [25:0].
REQ-024 With ZERO_UNUSED=0, all fields SHALL update together from the same instruction on every load.
REQ-025 With ZERO_UNUSED=1, formats SHALL be decoded as follows.
- R-format (opcode 000000): address=0, addressJump=0.
- I-format (opcodes 100011, 101011, 001001, 001010, 000100): rd=shamt=funct=0, addressJump=0.
- Any other opcode is J-format: rs=rt=rd=shamt=funct=0, address=0.
REQ-026 flush=1 SHALL take priority over IFIDWrite and in_valid.
- count becomes 0 and both pointers 0.
- out_valid becomes 0, PC4_out becomes 0, fields decode NOP_INSTR.
- The same-cycle input is discarded, since in_ready=0.
REQ-027 Flush while IFIDWrite=0 SHALL still squash the output register.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, set count=0, pointers=0, out_valid=0, PC4_out=0, and fields to the NOP_INSTR decode.
REQ-029 in_ready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.
REQ-030 Reset asserted mid-stream SHALL discard all FIFO contents; no stale entry SHALL appear after release.

Verification
REQ-031 Bypass: count=0, IFIDWrite=1, in_valid=1, PC4=0x104, instrucao=0x8C220004 -> next cycle out_valid=1, PC4_out=0x104, opcode=0x23, rs=1, rt=2, address=0x0004, count=0.
REQ-032 Stall fill: IFIDWrite=0, push A then B -> count=2, in_ready=0, outputs unchanged; IFIDWrite=1 for 2 cycles -> A, then B appear in order, count 2->1->0.
REQ-033 Full push+pop: DEPTH=2 full, IFIDWrite=1, in_valid=1 -> in_ready=0, one pop, count=1, offered word is not lost (accepted next cycle).
REQ-034 Flush: count=2, out_valid=1, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, PC4_out=0, opcode=0; the input is dropped.
REQ-035 ZERO_UNUSED=1 jump: instrucao=0x08000040 -> opcode=0x02, addressJump=0x0000040, rs=rt=rd=shamt=funct=0, address=0.
REQ-036 Async reset: reset_n pulsed low between clock edges with count=1 -> out_valid=0 and count=0 before the next rising edge.
